// File: rtl/alu_sequencer.sv
// Control sequencer for a register-file/ALU datapath: walks each instruction
// through operand fetch, ALU operation, optional MUL/DIV wait and write-back.
module alu_sequencer #(
  parameter int unsigned MULDIV_LAT = 0
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  alu_opcode,
  output logic        reg_out,
  output logic [3:0]  reg_out_sel,
  output logic        reg_in,
  output logic [3:0]  reg_in_sel,
  output logic        yin,
  output logic        zin,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        hi_in,
  output logic        lo_in
);

  typedef enum logic [2:0] {
    IDLE, FETCH_B, OPER, WAIT, WB_LO, WB_HI, ERR
  } state_t;

  localparam logic [3:0] LAT_LAST = (MULDIV_LAT > 0) ? 4'(MULDIV_LAT - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;
  logic [3:0] cnt_q, cnt_d;

  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[14:0];

  function automatic logic is_binary(input logic [4:0] op);
    return (op >= 5'b00011) && (op <= 5'b01011);
  endfunction

  function automatic logic is_wide(input logic [4:0] op);
    return (op == 5'b01111) || (op == 5'b10000);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == 5'b10001) || (op == 5'b10010);
  endfunction

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    rc_d        = rc_q;
    cnt_d       = cnt_q;
    busy        = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    alu_opcode  = 5'b00000;
    reg_out     = 1'b0;
    reg_out_sel = 4'd0;
    reg_in      = 1'b0;
    reg_in_sel  = 4'd0;
    yin         = 1'b0;
    zin         = 1'b0;
    zlow_out    = 1'b0;
    zhigh_out   = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = ir[31:27];
          ra_d = ir[26:23];
          rb_d = ir[22:19];
          rc_d = ir[18:15];
          if (is_binary(ir[31:27]) || is_wide(ir[31:27])) begin
            state_d = FETCH_B;
          end else if (is_unary(ir[31:27])) begin
            state_d = OPER;
          end else begin
            state_d = ERR;
          end
        end
      end
      FETCH_B: begin
        busy        = 1'b1;
        reg_out     = 1'b1;
        reg_out_sel = rb_q;
        yin         = 1'b1;
        state_d     = OPER;
      end
      OPER: begin
        busy        = 1'b1;
        reg_out     = 1'b1;
        reg_out_sel = is_unary(op_q) ? rb_q : rc_q;
        alu_opcode  = op_q;
        // Slow MUL/DIV defer the Z capture to the last WAIT cycle.
        if (is_wide(op_q) && (MULDIV_LAT > 0)) begin
          cnt_d   = 4'd0;
          state_d = WAIT;
        end else begin
          zin     = 1'b1;
          state_d = WB_LO;
        end
      end
      WAIT: begin
        busy        = 1'b1;
        reg_out     = 1'b1;
        reg_out_sel = rc_q;
        alu_opcode  = op_q;
        if (cnt_q == LAT_LAST) begin
          zin     = 1'b1;
          cnt_d   = 4'd0;
          state_d = WB_LO;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WB_LO: begin
        busy     = 1'b1;
        zlow_out = 1'b1;
        if (is_wide(op_q)) begin
          lo_in   = 1'b1;
          state_d = WB_HI;
        end else begin
          reg_in     = 1'b1;
          reg_in_sel = ra_q;
          done       = 1'b1;
          state_d    = IDLE;
        end
      end
      WB_HI: begin
        busy      = 1'b1;
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        busy    = 1'b1;
        done    = 1'b1;
        illegal = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (MULDIV_LAT 0 and 3) share stimulus;
// per-cycle expected output vectors are queued at start and popped each cycle.
module tb_alu_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic [4:0] alu_opcode;
    logic       reg_out;
    logic [3:0] reg_out_sel;
    logic       reg_in;
    logic [3:0] reg_in_sel;
    logic       yin;
    logic       zin;
    logic       zlow_out;
    logic       zhigh_out;
    logic       hi_in;
    logic       lo_in;
  } outv_t;

  typedef struct {
    logic [31:0] instr;
    int          doneAt0;
    int          doneAt3;
    logic        illegalExp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = 32'd0;

  logic       busy0, done0, illegal0, regOut0, regIn0, yin0, zin0, zlo0, zhi0, hiIn0, loIn0;
  logic [4:0] opc0;
  logic [3:0] outSel0, inSel0;
  logic       busy3, done3, illegal3, regOut3, regIn3, yin3, zin3, zlo3, zhi3, hiIn3, loIn3;
  logic [4:0] opc3;
  logic [3:0] outSel3, inSel3;

  outv_t act0, act3;
  outv_t sb0[$];
  outv_t sb3[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cycStart = 0;
  int done0Cnt, done3Cnt, lastDone0, lastDone3;
  logic sawIllegal0, sawIllegal3;

  always #5 clk = ~clk;

  alu_sequencer #(.MULDIV_LAT(0)) dut0 (
    .clk(clk), .clear(clear), .start(start), .ir(ir),
    .busy(busy0), .done(done0), .illegal(illegal0), .alu_opcode(opc0),
    .reg_out(regOut0), .reg_out_sel(outSel0), .reg_in(regIn0), .reg_in_sel(inSel0),
    .yin(yin0), .zin(zin0), .zlow_out(zlo0), .zhigh_out(zhi0),
    .hi_in(hiIn0), .lo_in(loIn0)
  );

  alu_sequencer #(.MULDIV_LAT(3)) dut3 (
    .clk(clk), .clear(clear), .start(start), .ir(ir),
    .busy(busy3), .done(done3), .illegal(illegal3), .alu_opcode(opc3),
    .reg_out(regOut3), .reg_out_sel(outSel3), .reg_in(regIn3), .reg_in_sel(inSel3),
    .yin(yin3), .zin(zin3), .zlow_out(zlo3), .zhigh_out(zhi3),
    .hi_in(hiIn3), .lo_in(loIn3)
  );

  always_comb begin
    act0 = {busy0, done0, illegal0, opc0, regOut0, outSel0, regIn0, inSel0,
            yin0, zin0, zlo0, zhi0, hiIn0, loIn0};
    act3 = {busy3, done3, illegal3, opc3, regOut3, outSel3, regIn3, inSel3,
            yin3, zin3, zlo3, zhi3, hiIn3, loIn3};
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushOne(input int which, input outv_t v);
    if (which == 0) sb0.push_back(v);
    else sb3.push_back(v);
  endtask

  // Expected outputs for cycles 1..N of one instruction, straight from the cycle table.
  task automatic pushTrace(input logic [31:0] instr, input int lat, input int which);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       bin, wide, un;
    outv_t      v;
    op = instr[31:27];
    ra = instr[26:23];
    rb = instr[22:19];
    rc = instr[18:15];
    bin  = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                      5'b01000, 5'b01001, 5'b01010, 5'b01011};
    wide = op inside {5'b01111, 5'b10000};
    un   = op inside {5'b10001, 5'b10010};
    if (!(bin || wide || un)) begin
      v = '0; v.busy = 1'b1; v.done = 1'b1; v.illegal = 1'b1;
      pushOne(which, v);
      return;
    end
    if (!un) begin
      v = '0; v.busy = 1'b1; v.reg_out = 1'b1; v.reg_out_sel = rb; v.yin = 1'b1;
      pushOne(which, v);
    end
    v = '0; v.busy = 1'b1; v.reg_out = 1'b1; v.reg_out_sel = un ? rb : rc;
    v.alu_opcode = op; v.zin = !(wide && lat > 0);
    pushOne(which, v);
    if (wide) begin
      for (int i = 0; i < lat; i++) begin
        v = '0; v.busy = 1'b1; v.reg_out = 1'b1; v.reg_out_sel = rc;
        v.alu_opcode = op; v.zin = (i == lat - 1);
        pushOne(which, v);
      end
    end
    v = '0; v.busy = 1'b1; v.zlow_out = 1'b1;
    if (wide) v.lo_in = 1'b1;
    else begin v.reg_in = 1'b1; v.reg_in_sel = ra; v.done = 1'b1; end
    pushOne(which, v);
    if (wide) begin
      v = '0; v.busy = 1'b1; v.zhigh_out = 1'b1; v.hi_in = 1'b1; v.done = 1'b1;
      pushOne(which, v);
    end
  endtask

  task automatic resetTracking();
    done0Cnt = 0; done3Cnt = 0; lastDone0 = -1; lastDone3 = -1;
    sawIllegal0 = 1'b0; sawIllegal3 = 1'b0;
    cycStart = cyc + 1;
  endtask

  // One clock cycle: drive inputs after the edge, compare both DUTs mid-cycle.
  task automatic applyStimulus(input logic st, input logic [31:0] instr,
                               input logic clr, input string tag);
    outv_t e0, e3;
    @(posedge clk);
    #1;
    start = st;
    ir    = instr;
    clear = clr;
    cyc++;
    @(negedge clk);
    e0 = (sb0.size() > 0) ? sb0.pop_front() : '0;
    e3 = (sb3.size() > 0) ? sb3.pop_front() : '0;
    checkOutput($sformatf("%s lat0 c%0d", tag, cyc - cycStart), 32'(act0), 32'(e0));
    checkOutput($sformatf("%s lat3 c%0d", tag, cyc - cycStart), 32'(act3), 32'(e3));
    if (act0.done) begin done0Cnt++; lastDone0 = cyc - cycStart; end
    if (act3.done) begin done3Cnt++; lastDone3 = cyc - cycStart; end
    if (act0.illegal) sawIllegal0 = 1'b1;
    if (act3.illegal) sawIllegal3 = 1'b1;
  endtask

  task automatic drainQueues(input string tag, input logic holdStart,
                             input logic [31:0] holdIr, input int holdUntil);
    int budget;
    budget = 0;
    while ((sb0.size() > 0 || sb3.size() > 0) && budget < 40) begin
      if (holdStart && (cyc + 1 - cycStart) <= holdUntil)
        applyStimulus(1'b1, holdIr, 1'b1, tag);
      else
        applyStimulus(1'b0, $urandom, 1'b1, tag);
      budget++;
    end
    if (budget >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: queues not drained, got %0d entries, expected 0",
               tag, sb0.size() + sb3.size());
      sb0.delete();
      sb3.delete();
    end
    applyStimulus(1'b0, $urandom, 1'b1, tag);
  endtask

  task automatic runOp(input logic [31:0] instr, input string tag);
    resetTracking();
    applyStimulus(1'b1, instr, 1'b1, tag);
    pushTrace(instr, 0, 0);
    pushTrace(instr, 3, 1);
    drainQueues(tag, 1'b0, 32'd0, 0);
  endtask

  vec_t vecs[$];
  outv_t zeroV;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    zeroV = '0;
    vecs.push_back('{32'h18A20000,            3, 3, 1'b0, "ADD r1,r4,r4"});
    vecs.push_back('{mk(5'b00100, 2, 7, 9),   3, 3, 1'b0, "SUB"});
    vecs.push_back('{mk(5'b00101, 15, 1, 2),  3, 3, 1'b0, "AND"});
    vecs.push_back('{mk(5'b01000, 3, 10, 11), 3, 3, 1'b0, "SHRA"});
    vecs.push_back('{mk(5'b01011, 14, 13, 12),3, 3, 1'b0, "ROL"});
    vecs.push_back('{mk(5'b01111, 0, 2, 3),   4, 7, 1'b0, "MUL"});
    vecs.push_back('{mk(5'b10000, 8, 5, 6),   4, 7, 1'b0, "DIV"});
    vecs.push_back('{mk(5'b10010, 5, 6, 0),   2, 2, 1'b0, "NOT"});
    vecs.push_back('{mk(5'b10001, 9, 12, 7),  2, 2, 1'b0, "NEG"});
    vecs.push_back('{mk(5'b11111, 1, 2, 3),   1, 1, 1'b1, "OP11111"});
    vecs.push_back('{mk(5'b00000, 4, 4, 4),   1, 1, 1'b1, "OP00000"});
    vecs.push_back('{mk(5'b01100, 4, 4, 4),   1, 1, 1'b1, "OP01100"});
    vecs.push_back('{mk(5'b10011, 4, 4, 4),   1, 1, 1'b1, "OP10011"});

    $display("[TB] reset state");
    resetTracking();
    applyStimulus(1'b0, 32'd0, 1'b0, "reset");
    applyStimulus(1'b1, 32'h18A20000, 1'b0, "reset+start");
    applyStimulus(1'b0, 32'd0, 1'b1, "after reset");

    $display("[TB] vector table");
    foreach (vecs[k]) begin
      runOp(vecs[k].instr, vecs[k].name);
      checkOutput({vecs[k].name, " done cycle lat0"}, 32'(lastDone0), 32'(vecs[k].doneAt0));
      checkOutput({vecs[k].name, " done cycle lat3"}, 32'(lastDone3), 32'(vecs[k].doneAt3));
      checkOutput({vecs[k].name, " done count"}, 32'(done0Cnt + done3Cnt), 32'd2);
      checkOutput({vecs[k].name, " illegal lat0"}, 32'(sawIllegal0), 32'(vecs[k].illegalExp));
      checkOutput({vecs[k].name, " illegal lat3"}, 32'(sawIllegal3), 32'(vecs[k].illegalExp));
    end

    $display("[TB] clear during DIV wait");
    resetTracking();
    applyStimulus(1'b1, mk(5'b10000, 7, 2, 3), 1'b1, "clrdiv");
    pushTrace(mk(5'b10000, 7, 2, 3), 0, 0);
    pushTrace(mk(5'b10000, 7, 2, 3), 3, 1);
    applyStimulus(1'b0, $urandom, 1'b1, "clrdiv");
    applyStimulus(1'b0, $urandom, 1'b1, "clrdiv");
    applyStimulus(1'b0, $urandom, 1'b0, "clrdiv");
    sb0.delete();
    sb3.delete();
    applyStimulus(1'b0, $urandom, 1'b1, "clrdiv");
    applyStimulus(1'b0, $urandom, 1'b1, "clrdiv");
    checkOutput("clrdiv no done", 32'(done0Cnt + done3Cnt), 32'd0);
    runOp(32'h18A20000, "ADD after clear");
    checkOutput("ADD after clear done cycle", 32'(lastDone3), 32'd3);

    $display("[TB] clear overriding start");
    resetTracking();
    applyStimulus(1'b1, 32'h18A20000, 1'b0, "clrstart");
    applyStimulus(1'b0, 32'h18A20000, 1'b1, "clrstart");
    applyStimulus(1'b0, 32'h18A20000, 1'b1, "clrstart");
    checkOutput("clrstart no done", 32'(done0Cnt + done3Cnt), 32'd0);

    $display("[TB] back-to-back ADDs with start held");
    resetTracking();
    applyStimulus(1'b1, mk(5'b00011, 1, 4, 4), 1'b1, "b2b");
    pushTrace(mk(5'b00011, 1, 4, 4), 0, 0);
    pushTrace(mk(5'b00011, 1, 4, 4), 3, 1);
    pushOne(0, zeroV);
    pushOne(1, zeroV);
    pushTrace(mk(5'b00011, 11, 2, 13), 0, 0);
    pushTrace(mk(5'b00011, 11, 2, 13), 3, 1);
    drainQueues("b2b", 1'b1, mk(5'b00011, 11, 2, 13), 4);
    checkOutput("b2b done count lat0", 32'(done0Cnt), 32'd2);
    checkOutput("b2b second done cycle", 32'(lastDone0), 32'd7);
    checkOutput("b2b second done cycle lat3", 32'(lastDone3), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 0, meaning extra wait cycles (0-15) inserted before Z capture for MUL and DIV only.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clear  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request to execute the instruction on ir; sampled only in IDLE.
REQ-005 ir  input  32  instruction: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
REQ-006 busy  output  1  high in every non-IDLE state.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 illegal  output  1  qualifies done; high when the opcode was unsupported.
REQ-009 alu_opcode  output  5  opcode presented to the ALU.
REQ-010 reg_out, reg_out_sel  output  1, 4  register-file bus drive enable and source index.
REQ-011 reg_in, reg_in_sel  output  1, 4  register-file write enable and destination index.
REQ-012 yin, zin, zlow_out, zhigh_out, hi_in, lo_in  output  1 each  Y load, Z capture, Z half-bus drives, HI/LO loads.

Function
REQ-013 Supported opcodes SHALL be: binary ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011; wide MUL 01111, DIV 10000; unary NEG 10001, NOT 10010; all others are illegal.
REQ-014 ir SHALL be latched when start=1 in IDLE; later ir changes SHALL have no effect until the next IDLE.
REQ-015 States SHALL be IDLE, FETCH_B, OPER, WAIT, WB_LO, WB_HI, ERR.
REQ-016 IDLE+start: binary or wide -> FETCH_B; unary -> OPER; illegal -> ERR.
REQ-017 FETCH_B (one cycle): reg_out=1, reg_out_sel=Rb, yin=1 -> OPER.
REQ-018 OPER: reg_out=1, reg_out_sel=Rc for binary/wide, Rb for unary; alu_opcode=latched opcode; zin=1 only when no WAIT follows.
REQ-019 WAIT (wide only, MULDIV_LAT>0): OPER outputs held, 4-bit counter counts MULDIV_LAT cycles, zin=1 in the last WAIT cycle only; MULDIV_LAT=0 skips WAIT.
REQ-020 WB_LO: zlow_out=1; non-wide: reg_in=1, reg_in_sel=Ra, done=1 -> IDLE; wide: lo_in=1 -> WB_HI.
REQ-021 WB_HI: zhigh_out=1, hi_in=1, done=1 -> IDLE.
REQ-022 ERR (one cycle): done=1, illegal=1, no strobes -> IDLE.
REQ-023 Latency, start cycle = 0: binary done in cycle 3, unary cycle 2, wide cycle 4+MULDIV_LAT, illegal cycle 1.
REQ-024 start while busy SHALL be ignored, not queued; start in the IDLE cycle immediately after done SHALL be accepted.
REQ-025 At most one bus driver (reg_out, zlow_out, zhigh_out) SHALL be high in any cycle.
REQ-026 alu_opcode SHALL be 00000 outside OPER/WAIT; index outputs SHALL be 0 when their enable is low.

Reset
REQ-027 clear=0 at a rising edge SHALL force IDLE, clear the WAIT counter and latched ir, and drive every output 0 from that edge on, including mid-operation; no done is produced for an aborted instruction.
REQ-028 clear=0 SHALL override a simultaneous start.

Verification
REQ-029 ir=0x18A20000 (ADD Ra=1, Rb=4, Rc=4), start one cycle -> c1 yin, reg_out_sel=4; c2 alu_opcode=00011, zin; c3 zlow_out, reg_in, reg_in_sel=1, done.
REQ-030 MULDIV_LAT=3, MUL Rb=2, Rc=3 -> zin only in c5; c6 lo_in+zlow_out; c7 hi_in+zhigh_out+done; reg_in never high.
REQ-031 NOT Ra=5, Rb=6 -> no yin; c1 alu_opcode=10010, reg_out_sel=6, zin; c2 reg_in_sel=5, done.
REQ-032 Opcode 11111 -> c1 done=1, illegal=1, all strobes 0; then IDLE.
REQ-033 clear=0 during a DIV WAIT cycle -> next cycle all outputs 0, busy=0, no done; a following ADD completes normally.
REQ-034 start held high across two ADDs, ir changed mid-op -> each op uses the ir latched at its start; back-to-back done pulses 4 cycles apart.
